// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Multi-cycle WIDTH-bit unsigned adder built around a single 4-bit add
//   slice. A start pulse latches the operands. The slice then processes one
//   nibble per clock, least significant nibble first. The slice carry-out is
//   carried into the next nibble through a register, so no wide
//   combinational adder is needed.
//
// Parameters
//   WIDTH  operand/result width (multiple of 4, >= 8)
//
// Ports
//   clock  in   rising-edge clock
//   reset  in   synchronous active-high reset
//   start  in   request, honoured only while busy=0
//   a, b   in   operands, sampled on the accepted start edge
//   cin    in   carry into nibble 0, sampled on the accepted start edge
//   busy   out  high while a computation is in progress
//   done   out  one-cycle pulse when s/cout present a new result
//   s      out  registered sum, (a + b + cin) mod 2^WIDTH
//   cout   out  registered carry out of the top nibble
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = $clog2(NIBBLES);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] partial_q, partial_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;

    logic [4:0]       slice_sum;
    logic             last_nibble;

    // The single 4-bit slice: {c4, sum4} = A[3:0] + B[3:0] + carry.
    assign slice_sum   = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, carry_q};
    assign last_nibble = (idx_q == IDX_W'(NIBBLES - 1));

    // ------------------------------------------------------------------
    // State register and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            partial_q <= '0;
            s_q       <= '0;
            cout_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            carry_q   <= carry_d;
            a_q       <= a_d;
            b_q       <= b_d;
            partial_q <= partial_d;
            s_q       <= s_d;
            cout_q    <= cout_d;
            done_q    <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start)       state_d = RUN;
            RUN:  if (last_nibble) state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        idx_d     = idx_q;
        carry_d   = carry_q;
        a_d       = a_q;
        b_d       = b_q;
        partial_d = partial_q;
        s_d       = s_q;
        cout_d    = cout_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d       = a;
                    b_d       = b;
                    carry_d   = cin;
                    idx_d     = '0;
                    partial_d = '0;
                end
            end
            RUN: begin
                // Operands shift down so the slice always sees bits [3:0];
                // sums enter at the top so after NIBBLES steps the partial
                // register holds the result in its natural bit order.
                a_d       = a_q >> 4;
                b_d       = b_q >> 4;
                partial_d = {slice_sum[3:0], partial_q[WIDTH-1:4]};
                carry_d   = slice_sum[4];
                idx_d     = idx_q + IDX_W'(1);
                if (last_nibble) begin
                    // Publish only the complete result so s never shows
                    // a partial sum.
                    s_d    = {slice_sum[3:0], partial_q[WIDTH-1:4]};
                    cout_d = slice_sum[4];
                    done_d = 1'b1;
                    idx_d  = '0;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = (state_q == RUN);
        done = done_q;
        s    = s_q;
        cout = cout_q;
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed testbench for nibble_serial_adder (WIDTH=16). Inputs are driven
// on the falling edge and outputs are sampled on the falling edge, so every
// sample sits half a period away from the active rising edge.
module tb_nibble_serial_adder;

    localparam int WIDTH = 16;

    logic             clock;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;

    int checks;
    int errors;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One rising edge, then back to the sampling point on the falling edge.
    task automatic tick();
        @(negedge clock);
    endtask

    // Present a request for one rising edge (the accept edge), then drop start.
    task automatic start_add(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                             input logic cv);
        $display("start a=%h b=%h cin=%0d", av, bv, cv);
        a     = av;
        b     = bv;
        cin   = cv;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Count rising edges after the accept edge until done is seen (bounded).
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        cin   = 1'b1;
        tick();
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl busy=%b done=%b expected busy=0 done=0", busy, done);
        end
        checks++;
        if (s !== 16'h0000 || cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_result s=%h cout=%b expected s=0000 cout=0", s, cout);
        end
        // start held with reset: reset must win, nothing runs afterwards
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL reset_priority cyc=%0d busy=%b done=%b expected 0 0", i, busy, done);
            end
        end
        $display("reset done");
    endtask

    task automatic test_t1_basic();
        start_add(16'h1234, 16'h0001, 1'b0);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL t1_accept busy=%b done=%b expected busy=1 done=0", busy, done);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b1 || s !== 16'h0000) begin
                errors++;
                $display("FAIL t1_run edge=%0d done=%b busy=%b s=%h expected 0 1 0000",
                         i, done, busy, s);
            end
        end
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t1_latency done=%b busy=%b after 4th edge, expected done=1 busy=0",
                     done, busy);
        end
        checks++;
        if (s !== 16'h1235 || cout !== 1'b0) begin
            errors++;
            $display("FAIL t1_result s=%h cout=%b expected s=1235 cout=0", s, cout);
        end
        tick();
        checks++;
        if (done !== 1'b0 || s !== 16'h1235) begin
            errors++;
            $display("FAIL t1_pulse done=%b s=%h expected done=0 s=1235", done, s);
        end
        $display("t1 s=%h cout=%b", s, cout);
    endtask

    task automatic test_t2_ripple();
        int n;
        start_add(16'hFFFF, 16'h0000, 1'b1);
        wait_done(n);
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL t2_latency edges=%0d expected 4", n);
        end
        checks++;
        if (s !== 16'h0000 || cout !== 1'b1) begin
            errors++;
            $display("FAIL t2_result s=%h cout=%b expected s=0000 cout=1", s, cout);
        end
        $display("t2 s=%h cout=%b", s, cout);
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        start_add(16'h8000, 16'h8000, 1'b0);
        wait_done(n);
        checks++;
        if (n != 4 || s !== 16'h0000 || cout !== 1'b1) begin
            errors++;
            $display("FAIL t3_first edges=%0d s=%h cout=%b expected 4 0000 1", n, s, cout);
        end
        // start in the done cycle is accepted immediately
        start_add(16'h0F0F, 16'h00F1, 1'b1);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || s !== 16'h0000 || cout !== 1'b1) begin
            errors++;
            $display("FAIL t3_b2b_accept done=%b busy=%b s=%h cout=%b expected 0 1 0000 1",
                     done, busy, s, cout);
        end
        wait_done(n);
        checks++;
        if (n != 4 || s !== 16'h1001 || cout !== 1'b0) begin
            errors++;
            $display("FAIL t3_second edges=%0d s=%h cout=%b expected 4 1001 0", n, s, cout);
        end
        $display("t3 s=%h cout=%b", s, cout);
        tick();
    endtask

    task automatic test_ignore_start();
        int pulses;
        logic [WIDTH-1:0] s_at_done;
        logic             c_at_done;
        pulses    = 0;
        s_at_done = 'x;
        c_at_done = 1'bx;
        start_add(16'h0001, 16'h0001, 1'b0);
        tick();
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        cin   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) begin
                pulses++;
                s_at_done = s;
                c_at_done = cout;
            end
            tick();
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL t4_pulses count=%0d expected 1", pulses);
        end
        checks++;
        if (s_at_done !== 16'h0002 || c_at_done !== 1'b0) begin
            errors++;
            $display("FAIL t4_result s=%h cout=%b expected s=0002 cout=0", s_at_done, c_at_done);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL t4_idle busy=%b expected 0", busy);
        end
        $display("t4 s=%h cout=%b", s, cout);
    endtask

    task automatic test_abort();
        int n;
        start_add(16'hABCD, 16'h1111, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || s !== 16'h0000 || cout !== 1'b0) begin
            errors++;
            $display("FAIL t5_abort busy=%b done=%b s=%h cout=%b expected 0 0 0000 0",
                     busy, done, s, cout);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL t5_no_done cyc=%0d done=%b busy=%b expected 0 0", i, done, busy);
            end
        end
        start_add(16'h0002, 16'h0003, 1'b0);
        wait_done(n);
        checks++;
        if (n != 4 || s !== 16'h0005 || cout !== 1'b0) begin
            errors++;
            $display("FAIL t5_next edges=%0d s=%h cout=%b expected 4 0005 0", n, s, cout);
        end
        $display("t5 s=%h cout=%b", s, cout);
        tick();
    endtask

    task automatic test_hold();
        int n;
        start_add(16'h1234, 16'h0001, 1'b0);
        wait_done(n);
        checks++;
        if (n != 4 || s !== 16'h1235) begin
            errors++;
            $display("FAIL t6_setup edges=%0d s=%h expected 4 1235", n, s);
        end
        for (int i = 0; i < 20; i++) begin
            a   = ~a ^ 16'(i * 16'h1357);
            b   = b + 16'h0F0F;
            cin = ~cin;
            tick();
            checks++;
            if (s !== 16'h1235 || cout !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL t6_hold cyc=%0d s=%h cout=%b done=%b expected 1235 0 0",
                         i, s, cout, done);
            end
        end
        $display("t6 s=%h cout=%b", s, cout);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        cin    = 1'b0;
        @(negedge clock);
        test_reset();
        test_t1_basic();
        test_t2_ripple();
        test_back_to_back();
        test_ignore_start();
        test_abort();
        test_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
